led_pattern_gen: RTL and testbench

//  Parametrised board-LED pattern engine for status/demo indication. Divides clk to a

---
 rtl/led_pattern_pkg.sv | 13 +
 rtl/led_tick_div.sv | 47 ++++
 rtl/led_pattern_gen.sv | 160 ++++++++++++++++
 tb/tb_led_pattern_gen.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/led_pattern_pkg.sv
// Shared pattern-mode encoding for the LED pattern engine.
package led_pattern_pkg;

  typedef enum logic [2:0] {
    OFF      = 3'd0,
    ROT_L    = 3'd1,
    ROT_R    = 3'd2,
    PINGPONG = 3'd3,
    BAR      = 3'd4,
    BLINK    = 3'd5
  } led_mode_t;

endpackage : led_pattern_pkg

// File: rtl/led_tick_div.sv
// Step-rate divider: counts enabled clk cycles and flags the last cycle of each step.
module led_tick_div #(
  parameter int CLK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise count while enabled and hold when frozen.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = CNT_ZERO;
    end else if (en) begin
      if (cnt_q == CNT_MAX) begin
        cnt_d = CNT_ZERO;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= CNT_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CNT_MAX);

endmodule : led_tick_div

// File: rtl/led_pattern_gen.sv
// Board-LED pattern engine: divided step tick advances a selectable lit-vector pattern.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int N_LED      = 8,
  parameter int CLK_DIV    = 50_000_000,
  parameter int ACTIVE_LOW = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [2:0]       mode,
  output logic [N_LED-1:0] led_o,
  output logic             tick_o,
  output logic             wrap_o
);

  if (N_LED < 1) begin : g_chk_n_led
    $error("led_pattern_gen: N_LED must be >= 1");
  end
  if (CLK_DIV < 1) begin : g_chk_clk_div
    $error("led_pattern_gen: CLK_DIV must be >= 1");
  end

  localparam logic [N_LED-1:0] PAT_ZERO = {N_LED{1'b0}};
  localparam logic [N_LED-1:0] PAT_ONES = {N_LED{1'b1}};
  localparam logic [N_LED-1:0] PAT_LSB  = N_LED'(1);
  localparam logic [N_LED-1:0] PAT_MSB  = PAT_LSB << (N_LED - 1);
  localparam logic [N_LED-1:0] LED_OFF  = (ACTIVE_LOW != 0) ? PAT_ONES : PAT_ZERO;
  localparam logic             DIR_UP   = 1'b1;
  localparam logic             DIR_DN   = 1'b0;

  // Pattern loaded when a mode is (re)selected.
  function automatic logic [N_LED-1:0] seed_f(input logic [2:0] m);
    logic [N_LED-1:0] s;
    case (led_mode_t'(m))
      ROT_L:    s = PAT_LSB;
      ROT_R:    s = PAT_MSB;
      PINGPONG: s = PAT_LSB;
      default:  s = PAT_ZERO;
    endcase
    return s;
  endfunction

  logic [2:0]       mode_q, mode_d;
  logic [N_LED-1:0] pat_q, pat_d;
  logic             dir_q, dir_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic [N_LED-1:0] led_q, led_d;
  logic             mode_chg_s;
  logic             div_tick_s;
  logic             step_s;
  logic [N_LED-1:0] shl_s;
  logic [N_LED-1:0] shr_s;

  assign mode_chg_s = (mode != mode_q);
  assign step_s     = div_tick_s && !mode_chg_s;
  assign shl_s      = pat_q << 1;
  assign shr_s      = pat_q >> 1;

  led_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (mode_chg_s),
    .tick (div_tick_s)
  );

  // Pattern next state: a mode change reloads the seed and beats a coincident step.
  always_comb begin
    mode_d = mode_q;
    pat_d  = pat_q;
    dir_d  = dir_q;
    wrap_d = 1'b0;
    tick_d = 1'b0;
    if (mode_chg_s) begin
      mode_d = mode;
      pat_d  = seed_f(mode);
      dir_d  = DIR_UP;
    end else if (step_s) begin
      tick_d = 1'b1;
      case (led_mode_t'(mode_q))
        ROT_L: begin
          pat_d  = shl_s | (pat_q >> (N_LED - 1));
          wrap_d = pat_q[N_LED-1];
        end
        ROT_R: begin
          pat_d  = shr_s | (pat_q << (N_LED - 1));
          wrap_d = pat_q[0];
        end
        PINGPONG: begin
          if (N_LED == 1) begin
            pat_d  = PAT_LSB;
            wrap_d = 1'b1;
          end else if (dir_q == DIR_UP) begin
            pat_d = shl_s;
            if (shl_s[N_LED-1]) begin
              dir_d = DIR_DN;
            end else begin
              dir_d = DIR_UP;
            end
          end else begin
            pat_d = shr_s;
            if (shr_s[0]) begin
              dir_d  = DIR_UP;
              wrap_d = 1'b1;
            end else begin
              dir_d = DIR_DN;
            end
          end
        end
        BAR: begin
          if (pat_q == PAT_ONES) begin
            pat_d  = PAT_ZERO;
            wrap_d = 1'b1;
          end else begin
            pat_d = shl_s | PAT_LSB;
          end
        end
        BLINK: begin
          pat_d  = ~pat_q;
          wrap_d = (pat_q == PAT_ONES);
        end
        default: begin
          pat_d = PAT_ZERO;
        end
      endcase
    end else begin
      pat_d = pat_q;
    end
    led_d = (ACTIVE_LOW != 0) ? ~pat_d : pat_d;
  end

  // State and registered output flops.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mode_q <= 3'd0;
      pat_q  <= PAT_ZERO;
      dir_q  <= DIR_UP;
      tick_q <= 1'b0;
      wrap_q <= 1'b0;
      led_q  <= LED_OFF;
    end else begin
      mode_q <= mode_d;
      pat_q  <= pat_d;
      dir_q  <= dir_d;
      tick_q <= tick_d;
      wrap_q <= wrap_d;
      led_q  <= led_d;
    end
  end

  assign led_o  = led_q;
  assign tick_o = tick_q;
  assign wrap_o = wrap_q;

endmodule : led_pattern_gen

// File: tb/tb_led_pattern_gen.sv
// Directed self-checking bench for led_pattern_gen.
module tb_led_pattern_gen;

  logic       clk;
  logic       rstn, rstn_al, rstn1;
  logic       en;
  logic [2:0] mode, mode1;
  logic [7:0] led, led_al;
  logic [0:0] led1;
  logic       tick, wrap, tick_al, wrap_al, tick1, wrap1;

  int checks = 0;
  int errors = 0;

  led_pattern_gen #(.N_LED(8), .CLK_DIV(4), .ACTIVE_LOW(0)) dut (
    .clk(clk), .rstn(rstn), .en(en), .mode(mode),
    .led_o(led), .tick_o(tick), .wrap_o(wrap)
  );

  led_pattern_gen #(.N_LED(8), .CLK_DIV(4), .ACTIVE_LOW(1)) dut_al (
    .clk(clk), .rstn(rstn_al), .en(en), .mode(mode),
    .led_o(led_al), .tick_o(tick_al), .wrap_o(wrap_al)
  );

  led_pattern_gen #(.N_LED(1), .CLK_DIV(1), .ACTIVE_LOW(0)) dut1 (
    .clk(clk), .rstn(rstn1), .en(en), .mode(mode1),
    .led_o(led1), .tick_o(tick1), .wrap_o(wrap1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One full step of the main instance: no tick for 3 cycles, then the step.
  task automatic wait_step(input string tag, input logic [7:0] exp_led, input logic exp_wrap);
    clk_n(3);
    chk({tag, "_mid_tick"}, {7'd0, tick}, 8'h00);
    clk_n(1);
    chk({tag, "_led"}, led, exp_led);
    chk({tag, "_tick"}, {7'd0, tick}, 8'h01);
    chk({tag, "_wrap"}, {7'd0, wrap}, {7'd0, exp_wrap});
  endtask

  initial begin
    rstn = 1'b0; rstn_al = 1'b0; rstn1 = 1'b0;
    en = 1'b1; mode = 3'd1; mode1 = 3'd1;
    #12;
    chk("rst_led", led, 8'h00);
    chk("rst_tick", {7'd0, tick}, 8'h00);
    chk("rst_wrap", {7'd0, wrap}, 8'h00);
    chk("rst_led_al", led_al, 8'hFF);

    // ROT_L from reset release
    clk_n(1);
    rstn = 1'b1; rstn_al = 1'b1;
    clk_n(1);
    chk("rotl_seed", led, 8'h01);
    chk("rotl_seed_tick", {7'd0, tick}, 8'h00);
    chk("rotl_seed_al", led_al, 8'hFE);
    for (int k = 1; k < 8; k++) wait_step("rotl", 8'(1 << k), 1'b0);
    wait_step("rotl_wrap", 8'h01, 1'b1);

    // PINGPONG
    mode = 3'd3;
    clk_n(1);
    chk("pp_seed", led, 8'h01);
    chk("pp_seed_tick", {7'd0, tick}, 8'h00);
    for (int k = 1; k < 8; k++) wait_step("pp_up", 8'(1 << k), 1'b0);
    for (int k = 6; k >= 0; k--) wait_step("pp_dn", 8'(1 << k), (k == 0) ? 1'b1 : 1'b0);

    // BAR then BLINK
    mode = 3'd4;
    clk_n(1);
    chk("bar_seed", led, 8'h00);
    for (int k = 0; k < 8; k++) wait_step("bar", 8'((1 << (k + 1)) - 1), 1'b0);
    wait_step("bar_wrap", 8'h00, 1'b1);
    mode = 3'd5;
    clk_n(1);
    chk("blink_seed", led, 8'h00);
    wait_step("blink_on", 8'hFF, 1'b0);
    wait_step("blink_off", 8'h00, 1'b1);

    // Freeze with en=0 at cnt=2
    mode = 3'd1;
    clk_n(1);
    chk("frz_seed", led, 8'h01);
    clk_n(2);
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      clk_n(1);
      chk("frz_led", led, 8'h01);
      chk("frz_tick", {7'd0, tick}, 8'h00);
      chk("frz_wrap", {7'd0, wrap}, 8'h00);
    end
    en = 1'b1;
    clk_n(1);
    chk("frz_resume_1", {7'd0, tick}, 8'h00);
    clk_n(1);
    chk("frz_resume_2_tick", {7'd0, tick}, 8'h01);
    chk("frz_resume_2_led", led, 8'h02);

    // Mode change coincident with a step
    clk_n(3);
    mode = 3'd2;
    clk_n(1);
    chk("chg_led", led, 8'h80);
    chk("chg_tick", {7'd0, tick}, 8'h00);
    wait_step("rotr", 8'h40, 1'b0);

    // Undefined mode 7 behaves as OFF
    mode = 3'd7;
    clk_n(1);
    chk("m7_led", led, 8'h00);
    wait_step("m7_step", 8'h00, 1'b0);

    // ACTIVE_LOW instance: reset mid-pattern takes effect immediately
    mode = 3'd1;
    clk_n(1);
    chk("al_seed", led_al, 8'hFE);
    clk_n(4);
    chk("al_step", led_al, 8'hFD);
    clk_n(2);
    #2;
    rstn_al = 1'b0;
    #1;
    chk("al_rst_led", led_al, 8'hFF);
    chk("al_rst_tick", {7'd0, tick_al}, 8'h00);

    // N_LED=1, CLK_DIV=1, ROT_L
    clk_n(1);
    rstn1 = 1'b1;
    clk_n(1);
    chk("n1_seed_led", {7'd0, led1}, 8'h01);
    chk("n1_seed_tick", {7'd0, tick1}, 8'h00);
    for (int i = 0; i < 5; i++) begin
      clk_n(1);
      chk("n1_led", {7'd0, led1}, 8'h01);
      chk("n1_tick", {7'd0, tick1}, 8'h01);
      chk("n1_wrap", {7'd0, wrap1}, 8'h01);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_led_pattern_gen
